cycle_ctrl: RTL
===============

CYCLE_CTRL -- requirements
Module: cycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port reg_clk  input  1  divided clock (clk/8), produced from clk by the divider; sampled as data.
REQ-004 SHALL have port mem_ready  input  1  data memory access complete.
REQ-005 SHALL have port is_load  input  1  decoded instruction is a load; sampled at DECODE exit.
REQ-006 SHALL have port is_store  input  1  decoded instruction is a store; sampled at DECODE exit.
REQ-007 SHALL have port is_halt  input  1  decoded instruction is a halt; sampled at DECODE exit.
REQ-008 SHALL have port ir_we  output  1  instruction register write pulse.
REQ-009 SHALL have port pc_we  output  1  program counter write pulse.
REQ-010 SHALL have port rf_we  output  1  register file write pulse.
REQ-011 SHALL have port dmem_re  output  1  data memory read level.
REQ-012 SHALL have port dmem_we  output  1  data memory write level.
REQ-013 SHALL have port phase  output  3  current state encoding.
REQ-014 SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 SHALL derive tick = reg_clk & ~reg_clk_q (reg_clk_q = reg_clk delayed one clk); state changes occur only on tick cycles.
REQ-016 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 unreachable, recovers to IDLE on the next clk.
REQ-017 SHALL transition on tick: IDLE->FETCH, FETCH->DECODE, DECODE->EXEC, EXEC->MEM if a load or store was latched, otherwise EXEC->WB, MEM->WB only when mem_ready=1, WB->HALT if halt latched, otherwise WB->FETCH; HALT is terminal.
REQ-018 SHALL latch is_load, is_store and is_halt on the tick leaving DECODE; is_load and is_store both high SHALL be treated as a store.
REQ-019 SHALL, when tick occurs in MEM with mem_ready=0, remain in MEM and re-evaluate at the next tick; mem_ready outside a MEM tick SHALL be ignored.
REQ-020 SHALL pulse ir_we (registered) for exactly one clk in the cycle after the tick leaving FETCH.
REQ-021 SHALL pulse pc_we for one clk in the cycle after the tick leaving WB.
REQ-022 SHALL pulse rf_we for one clk on that same cycle unless the instruction is a store or a halt.
REQ-023 SHALL hold dmem_re (load) or dmem_we (store) high, registered, for every clk in which phase==MEM, and never both.
REQ-024 SHALL drive phase from the state register, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, when rst=0 at a clk edge, regardless of current state (including mid-MEM), set state=IDLE, clear all latches and reg_clk_q, and drive every output low (phase=0).
REQ-026 SHALL take its first FETCH on the first tick after rst returns high.

Configuration
REQ-027 SHALL, with RETIRE_CNT_EN defined, add output retired (32 bits, reset 0) that increments on each pc_we pulse and wraps 0xFFFFFFFF->0; without the macro, SHALL have neither the port nor the counter.

Structure
REQ-028 SHALL take the state encodings and the PHASE_W=3 constant from the shared package cycle_ctrl_pkg.
REQ-029 SHALL place tick generation in sub-module edge_rise (clk, rst, d -> pulse).

Verification
REQ-030 SHALL verify ALU instruction (no class inputs): phase sequence 1,2,3,5,1, one tick per step; ir_we, rf_we and pc_we each one clk wide, dmem_re/dmem_we never high.
REQ-031 SHALL verify load with mem_ready=1: phase 3->4->5; dmem_re high for exactly 8 clk; rf_we pulses.
REQ-032 SHALL verify store with mem_ready=0 for two ticks then 1: MEM lasts 3 ticks (24 clk); dmem_we high throughout; rf_we never pulses.
REQ-033 SHALL verify is_halt at decode: after WB, phase=6 and halted=1; no further pulses over 100 clk.
REQ-034 SHALL verify rst=0 asserted mid-MEM: next clk all outputs 0 and phase=0; after release, FETCH is entered on the first tick.
REQ-035 SHALL verify, with RETIRE_CNT_EN, that retired=3 after three instructions and wraps from 0xFFFFFFFF to 0 when preset by force.

Source files
------------

// File: rtl/cycle_ctrl_pkg.sv
// Shared state encodings and widths for the multi-cycle instruction sequencer.
package cycle_ctrl_pkg;

   localparam int unsigned PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // A store wins when decode flags both load and store.
   function automatic logic load_only(input logic ld, input logic st);
      return ld & ~st;
   endfunction

endpackage

// File: rtl/cycle_ctrl_edge_rise.sv
// Rising-edge detector on a clk-synchronous data input; one clk pulse per rise.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = d;
   end

   always_ff @(posedge clk) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= prev_d;
   end

   assign pulse = d & ~prev_q;

endmodule

// File: rtl/cycle_ctrl.sv
// Multi-cycle sequencer stepping once per reg_clk rising edge.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module cycle_ctrl
   import cycle_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               reg_clk,
   input  logic               mem_ready,
   input  logic               is_load,
   input  logic               is_store,
   input  logic               is_halt,
   output logic               ir_we,
   output logic               pc_we,
   output logic               rf_we,
   output logic               dmem_re,
   output logic               dmem_we,
   output logic [PHASE_W-1:0] phase,
   output logic               halted
`ifdef RETIRE_CNT_EN
  ,output logic [31:0]        retired
`endif
);

   logic   tick;
   state_t state_q, state_d;
   logic   load_q, load_d;
   logic   store_q, store_d;
   logic   halt_q, halt_d;
   logic   ir_we_q, ir_we_d;
   logic   pc_we_q, pc_we_d;
   logic   rf_we_q, rf_we_d;
   logic   dmem_re_q, dmem_re_d;
   logic   dmem_we_q, dmem_we_d;

   edge_rise u_tick (
      .clk   (clk),
      .rst   (rst),
      .d     (reg_clk),
      .pulse (tick)
   );

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      store_d = store_q;
      halt_d  = halt_q;
      ir_we_d = 1'b0;
      pc_we_d = 1'b0;
      rf_we_d = 1'b0;
      case (state_q)
         ST_IDLE:   if (tick) state_d = ST_FETCH;
         ST_FETCH:  if (tick) begin
                       state_d = ST_DECODE;
                       ir_we_d = 1'b1;
                    end
         ST_DECODE: if (tick) begin
                       state_d = ST_EXEC;
                       load_d  = load_only(is_load, is_store);
                       store_d = is_store;
                       halt_d  = is_halt;
                    end
         ST_EXEC:   if (tick) state_d = (load_q | store_q) ? ST_MEM : ST_WB;
         ST_MEM:    if (tick && mem_ready) state_d = ST_WB;
         ST_WB:     if (tick) begin
                       state_d = halt_q ? ST_HALT : ST_FETCH;
                       pc_we_d = 1'b1;
                       rf_we_d = ~(store_q | halt_q);
                    end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
      // Built from the next state so the strobes line up exactly with phase==MEM.
      dmem_re_d = (state_d == ST_MEM) && load_q;
      dmem_we_d = (state_d == ST_MEM) && store_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         load_q    <= 1'b0;
         store_q   <= 1'b0;
         halt_q    <= 1'b0;
         ir_we_q   <= 1'b0;
         pc_we_q   <= 1'b0;
         rf_we_q   <= 1'b0;
         dmem_re_q <= 1'b0;
         dmem_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         load_q    <= load_d;
         store_q   <= store_d;
         halt_q    <= halt_d;
         ir_we_q   <= ir_we_d;
         pc_we_q   <= pc_we_d;
         rf_we_q   <= rf_we_d;
         dmem_re_q <= dmem_re_d;
         dmem_we_q <= dmem_we_d;
      end
   end

   assign ir_we   = ir_we_q;
   assign pc_we   = pc_we_q;
   assign rf_we   = rf_we_q;
   assign dmem_re = dmem_re_q;
   assign dmem_we = dmem_we_q;
   assign phase   = state_q;
   assign halted  = (state_q == ST_HALT);

`ifdef RETIRE_CNT_EN
   logic [31:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q + {31'd0, pc_we_q};
   end

   always_ff @(posedge clk) begin
      if (!rst) retired_q <= '0;
      else      retired_q <= retired_d;
   end

   assign retired = retired_q;
`endif

endmodule
